// File: rtl/mem_req_bridge.sv
// mem_req_bridge
// Adapts the CPU's single-cycle SRAM-style port to a req/addr_ok/data_ok
// memory protocol, stalling the CPU until each access completes.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   cpu_en, cpu_wen     : CPU access strobe and byte write enables (0 = read)
//   cpu_addr, cpu_wdata : CPU byte address and lane-aligned write data
//   cpu_flush           : abandon the current access
//   cpu_rdata           : read data, valid in DONE
//   cpu_stall           : freeze the CPU pipeline (combinational)
//   be_err              : pulse on acceptance of an illegal byte-enable pattern
//   req, wr, size, addr, wdata : registered memory request fields
//   addr_ok, data_ok, rdata    : memory request accept / response / read data
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; samples cpu_en
// REQ   | req high, fields held until addr_ok
// WAIT  | request accepted, waiting for data_ok
// DROP  | flushed after acceptance; swallow the coming data_ok
// DONE  | response captured in cpu_rdata, stall released for one cycle
module mem_req_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_en,
    input  logic [DATA_W/8-1:0]       cpu_wen,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    input  logic                      cpu_flush,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_stall,
    output logic                      be_err,
    output logic                      req,
    output logic                      wr,
    output logic [2:0]                size,
    output logic [ADDR_W-1:0]         addr,
    output logic [DATA_W-1:0]         wdata,
    input  logic                      addr_ok,
    input  logic                      data_ok,
    input  logic [DATA_W-1:0]         rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int SZ_W  = 3;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP,
        S_DONE
    } state_t;

    state_t            state;

    logic              is_write;
    logic              be_legal;
    logic [BE_W-1:0]   run_mask;
    logic [SZ_W-1:0]   enc_size;
    logic [OFF_W-1:0]  enc_off;
    logic [SZ_W-1:0]   req_size_n;
    logic [OFF_W-1:0]  req_off_n;
    logic              unused_addr_lo;

    // Low address bits are always rebuilt from the byte enables.
    assign unused_addr_lo = ^cpu_addr[OFF_W-1:0];

    assign is_write = |cpu_wen;

    // Match the enables against every naturally aligned run of 2^s bytes.
    // Anything unmatched falls back to a full-width access at offset 0.
    always_comb begin
        be_legal = 1'b0;
        run_mask = '0;
        enc_size = SZ_W'(OFF_W);
        enc_off  = '0;
        for (int s = 0; s <= OFF_W; s++) begin
            for (int k = 0; k < (BE_W >> s); k++) begin
                for (int j = 0; j < BE_W; j++) begin
                    run_mask[j] = (j >= (k << s)) && (j < ((k + 1) << s));
                end
                if (cpu_wen == run_mask) begin
                    be_legal = 1'b1;
                    enc_size = SZ_W'(s);
                    enc_off  = OFF_W'(k << s);
                end
            end
        end
    end

    assign req_size_n = is_write ? enc_size : SZ_W'(OFF_W);
    assign req_off_n  = is_write ? enc_off  : '0;

    assign cpu_stall = (state == S_IDLE && cpu_en && !cpu_flush) ||
                       (state == S_REQ) || (state == S_WAIT) || (state == S_DROP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            req       <= 1'b0;
            wr        <= 1'b0;
            size      <= '0;
            addr      <= '0;
            wdata     <= '0;
            cpu_rdata <= '0;
            be_err    <= 1'b0;
        end else begin
            be_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_en && !cpu_flush) begin
                        state  <= S_REQ;
                        req    <= 1'b1;
                        wr     <= is_write;
                        size   <= req_size_n;
                        addr   <= {cpu_addr[ADDR_W-1:OFF_W], req_off_n};
                        wdata  <= is_write ? cpu_wdata : '0;
                        be_err <= is_write && !be_legal;
                    end
                end
                S_REQ: begin
                    // Once addr_ok is seen the slave owns the transaction, so a
                    // simultaneous flush must still wait for its data_ok.
                    if (addr_ok) begin
                        req   <= 1'b0;
                        state <= cpu_flush ? S_DROP : S_WAIT;
                    end else if (cpu_flush) begin
                        req   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (data_ok) begin
                        cpu_rdata <= rdata;
                        state     <= S_DONE;
                    end else if (cpu_flush) begin
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (data_ok) begin
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_bridge.sv
// Testbench for mem_req_bridge: 32-bit instance driven through a scoreboard
// of expected request fields and read responses, plus a 64-bit instance for
// wide-lane encoding and asynchronous reset.
module tb_mem_req_bridge;

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk;
    logic        rst;

    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_flush;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        be_err;
    logic        req;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    logic        cpu_en_w;
    logic [7:0]  cpu_wen_w;
    logic [31:0] cpu_addr_w;
    logic [63:0] cpu_wdata_w;
    logic        cpu_flush_w;
    logic [63:0] cpu_rdata_w;
    logic        cpu_stall_w;
    logic        be_err_w;
    logic        req_w;
    logic        wr_w;
    logic [2:0]  size_w;
    logic [31:0] addr_w;
    logic [63:0] wdata_w;
    logic        addr_ok_w;
    logic        data_ok_w;
    logic [63:0] rdata_w;

    int          n_chk;
    int          n_pass;
    req_t        req_q[$];
    logic [31:0] rsp_q[$];
    req_t        mon_e;
    logic [31:0] model_rdata;

    mem_req_bridge #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_en    (cpu_en),
        .cpu_wen   (cpu_wen),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_flush (cpu_flush),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .be_err    (be_err),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata)
    );

    mem_req_bridge #(.ADDR_W(32), .DATA_W(64)) u_dut_w (
        .clk       (clk),
        .rst       (rst),
        .cpu_en    (cpu_en_w),
        .cpu_wen   (cpu_wen_w),
        .cpu_addr  (cpu_addr_w),
        .cpu_wdata (cpu_wdata_w),
        .cpu_flush (cpu_flush_w),
        .cpu_rdata (cpu_rdata_w),
        .cpu_stall (cpu_stall_w),
        .be_err    (be_err_w),
        .req       (req_w),
        .wr        (wr_w),
        .size      (size_w),
        .addr      (addr_w),
        .wdata     (wdata_w),
        .addr_ok   (addr_ok_w),
        .data_ok   (data_ok_w),
        .rdata     (rdata_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Request monitor: while req is high the fields must match the pending
    // scoreboard entry every cycle; the entry retires on addr_ok or flush.
    always @(negedge clk) begin
        if (rst) begin
            req_q.delete();
        end else if (req) begin
            check_val("req_pending", 64'(req_q.size()), 64'd1);
            if (req_q.size() != 0) begin
                mon_e = req_q[0];
                check_val("req_wr",    64'(wr),    64'(mon_e.wr));
                check_val("req_size",  64'(size),  64'(mon_e.size));
                check_val("req_addr",  64'(addr),  64'(mon_e.addr));
                check_val("req_wdata", 64'(wdata), 64'(mon_e.wdata));
                if (addr_ok || cpu_flush) void'(req_q.pop_front());
            end
        end
    end

    task automatic do_access(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int a_dly, input int d_dly,
                             input logic [2:0] exp_size, input logic [31:0] exp_addr,
                             input logic exp_err);
        req_t        e;
        logic [31:0] exp_rd;
        @(posedge clk); #1;
        cpu_en    = 1'b1;
        cpu_wen   = wen;
        cpu_addr  = a;
        cpu_wdata = wd;
        e.wr    = (wen != 4'd0);
        e.size  = exp_size;
        e.addr  = exp_addr;
        e.wdata = (wen != 4'd0) ? wd : 32'd0;
        req_q.push_back(e);
        rsp_q.push_back(rd);
        #1;
        check_val("stall_idle_en", 64'(cpu_stall), 64'd1);
        @(posedge clk); #1;
        check_val("be_err", 64'(be_err), 64'(exp_err));
        check_val("req_rise", 64'(req), 64'd1);
        for (int i = 0; i < a_dly; i++) begin
            @(posedge clk); #1;
            check_val("req_held", 64'(req), 64'd1);
            check_val("stall_req", 64'(cpu_stall), 64'd1);
            check_val("be_err_once", 64'(be_err), 64'd0);
        end
        addr_ok = 1'b1;
        @(posedge clk); #1;
        addr_ok = 1'b0;
        check_val("req_fall", 64'(req), 64'd0);
        check_val("stall_wait", 64'(cpu_stall), 64'd1);
        check_val("be_err_clear", 64'(be_err), 64'd0);
        for (int i = 0; i < d_dly; i++) begin
            @(posedge clk); #1;
            check_val("stall_wait_hold", 64'(cpu_stall), 64'd1);
        end
        data_ok = 1'b1;
        rdata   = rd;
        @(posedge clk); #1;
        data_ok = 1'b0;
        rdata   = $urandom;
        exp_rd  = rsp_q.pop_front();
        check_val("stall_done", 64'(cpu_stall), 64'd0);
        check_val("cpu_rdata", 64'(cpu_rdata), 64'(exp_rd));
        model_rdata = exp_rd;
        cpu_en  = 1'b0;
        cpu_wen = 4'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_t e;
        n_chk = 0;  n_pass = 0;  model_rdata = 32'd0;
        rst = 1'b1;
        cpu_en = 1'b0; cpu_wen = 4'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_flush = 1'b0;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;
        cpu_en_w = 1'b0; cpu_wen_w = 8'd0; cpu_addr_w = 32'd0; cpu_wdata_w = 64'd0; cpu_flush_w = 1'b0;
        addr_ok_w = 1'b0; data_ok_w = 1'b0; rdata_w = 64'd0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_req",    64'(req),       64'd0);
        check_val("rst_wr",     64'(wr),        64'd0);
        check_val("rst_size",   64'(size),      64'd0);
        check_val("rst_addr",   64'(addr),      64'd0);
        check_val("rst_wdata",  64'(wdata),     64'd0);
        check_val("rst_rdata",  64'(cpu_rdata), 64'd0);
        check_val("rst_be_err", 64'(be_err),    64'd0);
        check_val("rst_stall",  64'(cpu_stall), 64'd0);
        rst = 1'b0;

        // wen, addr, wdata, rdata, addr_ok delay, data_ok delay, size, addr, be_err
        do_access(4'b0000, 32'h1000_0006, 32'h0,          32'hDEAD_BEEF, 0, 0, 3'd2, 32'h1000_0004, 1'b0);
        do_access(4'b0100, 32'h2000_0000, 32'h00AB_0000,  32'h0000_0001, 0, 0, 3'd0, 32'h2000_0002, 1'b0);
        do_access(4'b1100, 32'h2000_0000, 32'hABCD_0000,  32'h0000_0002, 0, 1, 3'd1, 32'h2000_0002, 1'b0);
        do_access(4'b0001, 32'h2000_0003, 32'h0000_0055,  32'h0000_0003, 1, 0, 3'd0, 32'h2000_0000, 1'b0);
        do_access(4'b1111, 32'h2000_0007, 32'h0102_0304,  32'h0000_0004, 0, 0, 3'd2, 32'h2000_0004, 1'b0);
        do_access(4'b0101, 32'h2000_0002, 32'h00CC_00DD,  32'h0000_0005, 0, 0, 3'd2, 32'h2000_0000, 1'b1);
        do_access(4'b0110, 32'h2000_0001, 32'h00EE_FF00,  32'h0000_0006, 0, 0, 3'd2, 32'h2000_0000, 1'b1);
        do_access(4'b0000, 32'h1000_0100, 32'h0,          32'hFACE_0FF1, 3, 5, 3'd2, 32'h1000_0100, 1'b0);

        // Flush while req is pending without addr_ok: request withdrawn.
        @(posedge clk); #1;
        cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h3000_0008;
        e.wr = 1'b0; e.size = 3'd2; e.addr = 32'h3000_0008; e.wdata = 32'd0;
        req_q.push_back(e);
        @(posedge clk); #1;
        cpu_flush = 1'b1;
        @(posedge clk); #1;
        cpu_flush = 1'b0; cpu_en = 1'b0;
        check_val("flush_req_drop", 64'(req), 64'd0);
        check_val("flush_req_idle", 64'(cpu_stall), 64'd0);
        data_ok = 1'b1; rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        data_ok = 1'b0;
        check_val("idle_dok_ignored", 64'(cpu_rdata), 64'(model_rdata));
        check_val("idle_dok_stall", 64'(cpu_stall), 64'd0);

        // Flush after acceptance: response is swallowed in DROP.
        @(posedge clk); #1;
        cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h4000_0010;
        e.wr = 1'b0; e.size = 3'd2; e.addr = 32'h4000_0010; e.wdata = 32'd0;
        req_q.push_back(e);
        @(posedge clk); #1;
        addr_ok = 1'b1;
        @(posedge clk); #1;
        addr_ok = 1'b0; cpu_flush = 1'b1;
        @(posedge clk); #1;
        cpu_flush = 1'b0; cpu_en = 1'b0;
        check_val("drop_stall", 64'(cpu_stall), 64'd1);
        @(posedge clk); #1;
        check_val("drop_stall_hold", 64'(cpu_stall), 64'd1);
        data_ok = 1'b1; rdata = 32'h1234_5678;
        @(posedge clk); #1;
        data_ok = 1'b0;
        check_val("drop_rdata_kept", 64'(cpu_rdata), 64'(model_rdata));
        check_val("drop_to_idle", 64'(cpu_stall), 64'd0);

        do_access(4'b0000, 32'h4000_0020, 32'h0, 32'hCAFE_F00D, 0, 0, 3'd2, 32'h4000_0020, 1'b0);

        // Reset between edges while in WAIT.
        @(posedge clk); #1;
        cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h5000_0004;
        e.wr = 1'b0; e.size = 3'd2; e.addr = 32'h5000_0004; e.wdata = 32'd0;
        req_q.push_back(e);
        @(posedge clk); #1;
        addr_ok = 1'b1;
        @(posedge clk); #1;
        addr_ok = 1'b0;
        #2;
        rst = 1'b1; cpu_en = 1'b0;
        #1;
        check_val("arst_rdata", 64'(cpu_rdata), 64'd0);
        check_val("arst_state", 64'(cpu_stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        data_ok = 1'b1; rdata = 32'h7777_7777;
        @(posedge clk); #1;
        data_ok = 1'b0;
        check_val("arst_dok_ignored", 64'(cpu_rdata), 64'd0);
        check_val("arst_dok_stall", 64'(cpu_stall), 64'd0);
        model_rdata = 32'd0;

        // Reset between edges while req is high.
        @(posedge clk); #1;
        cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h5000_0000;
        e.wr = 1'b0; e.size = 3'd2; e.addr = 32'h5000_0000; e.wdata = 32'd0;
        req_q.push_back(e);
        @(posedge clk); #1;
        check_val("arst_req_pre", 64'(req), 64'd1);
        #2;
        rst = 1'b1; cpu_en = 1'b0;
        #1;
        check_val("arst_req_async", 64'(req), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 64-bit lanes: upper-word write, then a read reset mid-WAIT.
        @(posedge clk); #1;
        cpu_en_w = 1'b1; cpu_wen_w = 8'hF0; cpu_addr_w = 32'h6000_0000;
        cpu_wdata_w = 64'h1122_3344_5566_7788;
        @(posedge clk); #1;
        check_val("w64_req",    64'(req_w),    64'd1);
        check_val("w64_wr",     64'(wr_w),     64'd1);
        check_val("w64_size",   64'(size_w),   64'd2);
        check_val("w64_addr",   64'(addr_w),   64'h6000_0004);
        check_val("w64_wdata",  wdata_w,       64'h1122_3344_5566_7788);
        check_val("w64_be_err", 64'(be_err_w), 64'd0);
        addr_ok_w = 1'b1;
        @(posedge clk); #1;
        addr_ok_w = 1'b0; data_ok_w = 1'b1; rdata_w = 64'hA5A5_5A5A_0F0F_F0F0;
        @(posedge clk); #1;
        data_ok_w = 1'b0; cpu_en_w = 1'b0; cpu_wen_w = 8'd0;
        check_val("w64_rdata", cpu_rdata_w, 64'hA5A5_5A5A_0F0F_F0F0);
        check_val("w64_stall_done", 64'(cpu_stall_w), 64'd0);
        @(posedge clk); #1;
        cpu_en_w = 1'b1; cpu_addr_w = 32'h6000_000C;
        @(posedge clk); #1;
        check_val("r64_size", 64'(size_w), 64'd3);
        check_val("r64_addr", 64'(addr_w), 64'h6000_0008);
        check_val("r64_wr",   64'(wr_w),   64'd0);
        addr_ok_w = 1'b1;
        @(posedge clk); #1;
        addr_ok_w = 1'b0;
        check_val("r64_stall_wait", 64'(cpu_stall_w), 64'd1);
        #2;
        rst = 1'b1; cpu_en_w = 1'b0;
        #1;
        check_val("r64_arst_rdata", cpu_rdata_w, 64'd0);
        check_val("r64_arst_state", 64'(cpu_stall_w), 64'd0);
        check_val("r64_arst_size",  64'(size_w), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        data_ok_w = 1'b1; rdata_w = 64'hFFFF_0000_FFFF_0000;
        @(posedge clk); #1;
        data_ok_w = 1'b0;
        check_val("r64_dok_ignored", cpu_rdata_w, 64'd0);
        check_val("r64_dok_stall", 64'(cpu_stall_w), 64'd0);

        repeat (2) @(posedge clk);
        check_val("sb_req_empty", 64'(req_q.size()), 64'd0);
        check_val("sb_rsp_empty", 64'(rsp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
